// File: rtl/varray_rle_writer.sv
// Run-length packer for the varray write port: equal consecutive elements merge into one write, issued 1 cycle after the closing accept.
// in_ready drops only for the single FLUSH cycle; the output side has no backpressure. VARRAY_WRITER_ZERO_SKIP_EN suppresses zero-valued runs.
module varray_rle_writer #(
  parameter int VIRTUAL_ELEMENT_WIDTH = 4,
  parameter int VIRTUAL_ADDR_BITS     = 16,
  parameter int MAX_RUN               = 31
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [VIRTUAL_ADDR_BITS-1:0]     base_addr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VIRTUAL_ELEMENT_WIDTH-1:0] in_data,
  input  logic                             in_last,
  output logic                             we,
  output logic [VIRTUAL_ADDR_BITS-1:0]     write_addr,
  output logic [4:0]                       write_addr_len,
  output logic [VIRTUAL_ELEMENT_WIDTH-1:0] dat_w,
  output logic                             done,
  output logic [VIRTUAL_ADDR_BITS-1:0]     total_len,
  output logic                             busy
);

  localparam logic [4:0] MAX_LEN = 5'(MAX_RUN);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                           state, state_nxt;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] run_val;
  logic [4:0]                       run_len;
  logic [VIRTUAL_ADDR_BITS-1:0]     run_start;
  logic [VIRTUAL_ADDR_BITS-1:0]     frame_cnt;

  logic                             accept;
  logic                             extend;
  logic                             emit;
  logic                             emit_done;
  logic [VIRTUAL_ADDR_BITS-1:0]     emit_addr;
  logic [4:0]                       emit_len;
  logic [VIRTUAL_ELEMENT_WIDTH-1:0] emit_dat;
  logic [VIRTUAL_ADDR_BITS-1:0]     frame_nxt;
  logic                             emit_we;

  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;
  assign extend   = (in_data == run_val) && (run_len < MAX_LEN);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_done = 1'b0;
    emit_addr = run_start;
    emit_len  = run_len;
    emit_dat  = run_val;
    frame_nxt = frame_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          frame_nxt = VIRTUAL_ADDR_BITS'(1);
          if (in_last) begin
            emit      = 1'b1;
            emit_done = 1'b1;
            emit_addr = base_addr;
            emit_len  = 5'd1;
            emit_dat  = in_data;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          frame_nxt = frame_cnt + VIRTUAL_ADDR_BITS'(1);
          if (extend) begin
            if (in_last) begin
              emit      = 1'b1;
              emit_done = 1'b1;
              emit_len  = run_len + 5'd1;
              state_nxt = IDLE;
            end
          end else begin
            emit = 1'b1;
            if (in_last) state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        emit      = 1'b1;
        emit_done = 1'b1;
        emit_len  = 5'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef VARRAY_WRITER_ZERO_SKIP_EN
  // Unwritten varray locations read back as zero, so zero runs need no write.
  assign emit_we = emit && (emit_dat != '0);
`else
  assign emit_we = emit;
`endif

  // Run tracking; frame_cnt follows frame_nxt so total_len sees the final element.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_val   <= '0;
      run_len   <= '0;
      run_start <= '0;
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_nxt;
      if (accept) begin
        if (state == IDLE) begin
          run_start <= base_addr;
          run_val   <= in_data;
          run_len   <= 5'd1;
        end else if (state == ACCUM) begin
          if (extend) begin
            run_len <= run_len + 5'd1;
          end else begin
            run_start <= run_start + VIRTUAL_ADDR_BITS'(run_len);
            run_val   <= in_data;
            run_len   <= 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we             <= 1'b0;
      write_addr     <= '0;
      write_addr_len <= '0;
      dat_w          <= '0;
      done           <= 1'b0;
      total_len      <= '0;
    end else begin
      we   <= emit_we;
      done <= emit_done;
      if (emit) begin
        write_addr     <= emit_addr;
        write_addr_len <= emit_len;
        dat_w          <= emit_dat;
      end
      if (emit_done) total_len <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_varray_rle_writer.sv
// Directed bench for varray_rle_writer: hand-computed run writes, done/total_len, wrap and reset cases.
module tb_varray_rle_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic        we;
  logic [15:0] write_addr;
  logic [4:0]  write_addr_len;
  logic [3:0]  dat_w;
  logic        done;
  logic [15:0] total_len;
  logic        busy;

  int errors = 0;
  int checks = 0;

  varray_rle_writer dut (
    .clk(clk), .reset(reset), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .we(we), .write_addr(write_addr), .write_addr_len(write_addr_len), .dat_w(dat_w),
    .done(done), .total_len(total_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Apply one cycle of input, then observe 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; base_addr = 16'd0; in_valid = 1'b0; in_data = 4'd0; in_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, total_len, busy, in_ready} !== {1'b0, 16'd0, 5'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%h len=%0d dat=%0d done=%b total=%0d busy=%b rdy=%b, want all zero with rdy=1",
               we, write_addr, write_addr_len, dat_w, done, total_len, busy, in_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_pair_run();
    base_addr = 16'd0;
    step(1'b1, 4'd12, 1'b0);
    checks++;
    if ({we, busy} !== 2'b01) begin errors++; $display("FAIL pair_first: we=%b busy=%b want we=0 busy=1", we, busy); end
    step(1'b1, 4'd12, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done} !== {1'b1, 16'd0, 5'd2, 4'd12, 1'b1}) begin
      errors++; $display("FAIL pair_write: we=%b addr=%h len=%0d dat=%0d done=%b want 1,0000,2,12,1", we, write_addr, write_addr_len, dat_w, done);
    end
    checks++;
    if (total_len !== 16'd2) begin errors++; $display("FAIL pair_total: got %0d want 2", total_len); end
  endtask

  task automatic test_triple_run();
    base_addr = 16'd10;
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    step(1'b1, 4'd6, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done} !== {1'b1, 16'd10, 5'd3, 4'd6, 1'b1}) begin
      errors++; $display("FAIL triple_write: we=%b addr=%h len=%0d dat=%0d done=%b want 1,000a,3,6,1", we, write_addr, write_addr_len, dat_w, done);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL triple_busy: got %b want 0", busy); end
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, done, total_len} !== {1'b0, 1'b0, 16'd3}) begin
      errors++; $display("FAIL triple_after: we=%b done=%b total=%0d want 0,0,3", we, done, total_len);
    end
  endtask

  task automatic test_break_flush();
    base_addr = 16'd0;
    step(1'b1, 4'd3, 1'b0);
    base_addr = 16'd99;
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd5, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, in_ready} !== {1'b1, 16'd0, 5'd2, 4'd3, 1'b0, 1'b0}) begin
      errors++; $display("FAIL break_write: we=%b addr=%h len=%0d dat=%0d done=%b rdy=%b want 1,0000,2,3,0,0",
                         we, write_addr, write_addr_len, dat_w, done, in_ready);
    end
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, total_len} !== {1'b1, 16'd2, 5'd1, 4'd5, 1'b1, 16'd3}) begin
      errors++; $display("FAIL flush_write: we=%b addr=%h len=%0d dat=%0d done=%b total=%0d want 1,0002,1,5,1,3",
                         we, write_addr, write_addr_len, dat_w, done, total_len);
    end
    checks++;
    if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL flush_idle: rdy=%b busy=%b want 1,0", in_ready, busy); end
  endtask

  task automatic test_max_run();
    logic [26:0] exp;
    logic [26:0] got;
    base_addr = 16'd0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 4'd7, (i == 39));
      if (i == 31)      exp = {1'b1, 16'd0,  5'd31, 4'd7, 1'b0};
      else if (i == 39) exp = {1'b1, 16'd31, 5'd9,  4'd7, 1'b1};
      else              exp = 27'd0;
      got = {we, write_addr, write_addr_len, dat_w, done};
      if (exp[26] == 1'b0) got = {we, 25'd0, done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL max_run[%0d]: got %h want %h", i, got, exp);
      end
    end
    checks++;
    if (total_len !== 16'd40) begin errors++; $display("FAIL max_run_total: got %0d want 40", total_len); end
  endtask

  task automatic test_wrap();
    base_addr = 16'hFFFE;
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done} !== {1'b1, 16'hFFFE, 5'd3, 4'd1, 1'b0}) begin
      errors++; $display("FAIL wrap_first: we=%b addr=%h len=%0d dat=%0d done=%b want 1,fffe,3,1,0", we, write_addr, write_addr_len, dat_w, done);
    end
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, total_len} !== {1'b1, 16'h0001, 5'd1, 4'd2, 1'b1, 16'd4}) begin
      errors++; $display("FAIL wrap_second: we=%b addr=%h len=%0d dat=%0d done=%b total=%0d want 1,0001,1,2,1,4",
                         we, write_addr, write_addr_len, dat_w, done, total_len);
    end
  endtask

  task automatic test_back_to_back();
    base_addr = 16'd20;
    step(1'b1, 4'd4, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done} !== {1'b1, 16'd20, 5'd1, 4'd4, 1'b1}) begin
      errors++; $display("FAIL b2b_first: we=%b addr=%h len=%0d dat=%0d done=%b want 1,0014,1,4,1", we, write_addr, write_addr_len, dat_w, done);
    end
    base_addr = 16'd30;
    step(1'b1, 4'd9, 1'b1);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, total_len} !== {1'b1, 16'd30, 5'd1, 4'd9, 1'b1, 16'd1}) begin
      errors++; $display("FAIL b2b_second: we=%b addr=%h len=%0d dat=%0d done=%b total=%0d want 1,001e,1,9,1,1",
                         we, write_addr, write_addr_len, dat_w, done, total_len);
    end
  endtask

  task automatic test_zero_run();
    logic exp_we;
`ifdef VARRAY_WRITER_ZERO_SKIP_EN
    exp_we = 1'b0;
`else
    exp_we = 1'b1;
`endif
    base_addr = 16'd4;
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd0, 1'b0);
    step(1'b1, 4'd9, 1'b1);
    checks++;
    if (we !== exp_we || done !== 1'b0) begin
      errors++; $display("FAIL zero_run_we: we=%b done=%b want %b,0", we, done, exp_we);
    end
    checks++;
    if (exp_we && {write_addr, write_addr_len, dat_w} !== {16'd4, 5'd2, 4'd0}) begin
      errors++; $display("FAIL zero_run_tuple: addr=%h len=%0d dat=%0d want 0004,2,0", write_addr, write_addr_len, dat_w);
    end
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, write_addr, write_addr_len, dat_w, done, total_len} !== {1'b1, 16'd6, 5'd1, 4'd9, 1'b1, 16'd3}) begin
      errors++; $display("FAIL zero_run_final: we=%b addr=%h len=%0d dat=%0d done=%b total=%0d want 1,0006,1,9,1,3",
                         we, write_addr, write_addr_len, dat_w, done, total_len);
    end
  endtask

  task automatic test_mid_run_reset();
    base_addr = 16'd50;
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    reset = 1'b0;
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, done, in_ready, busy, total_len} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      errors++; $display("FAIL mid_reset: we=%b done=%b rdy=%b busy=%b total=%0d want 0,0,1,0,0", we, done, in_ready, busy, total_len);
    end
    reset = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    checks++;
    if ({we, busy} !== 2'b00) begin errors++; $display("FAIL post_reset: we=%b busy=%b want 0,0", we, busy); end
  endtask

  initial begin
    test_reset();
    test_pair_run();
    test_triple_run();
    test_break_flush();
    test_max_run();
    test_wrap();
    test_back_to_back();
    test_zero_run();
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/varray_rle_writer.md
Name: varray_rle_writer

Overview:
- Write-side front end for the virtual array storage block.
- Consumes a valid/ready element stream, one frame terminated by `in_last`, and packs consecutive equal elements into run-length writes (`we`, `write_addr`, `write_addr_len`, `dat_w`).
- Those writes drive the varray write port directly. The varray accepts one write per cycle, so there is no backpressure on the output side.
- Sits between producer units (e.g. FIFO/ALU result drain) and varray.

Parameters:
- VIRTUAL_ELEMENT_WIDTH, 4, element data width.
- VIRTUAL_ADDR_BITS, 16, virtual address width.
- MAX_RUN, 31, maximum run length per write; must be 1..31 to fit the 5-bit length field.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- base_addr  input  VIRTUAL_ADDR_BITS  frame start address; sampled on the first accepted element of a frame.
- in_valid  input  1  element valid.
- in_ready  output  1  element ready.
- in_data  input  VIRTUAL_ELEMENT_WIDTH  element value.
- in_last  input  1  final element of frame.
- we  output  1  varray write strobe (registered).
- write_addr  output  VIRTUAL_ADDR_BITS  run start address.
- write_addr_len  output  5  run length, 1..MAX_RUN.
- dat_w  output  VIRTUAL_ELEMENT_WIDTH  run value.
- done  output  1  one-cycle pulse, coincident with the frame's final write.
- total_len  output  VIRTUAL_ADDR_BITS  element count of last completed frame.
- busy  output  1  high while a run is open or a flush is pending.

Behaviour:
- Reset (reset==0 at posedge):
  - Outputs: we=0, write_addr=0, write_addr_len=0, dat_w=0, done=0, total_len=0, busy=0.
  - State → IDLE, so in_ready=1 from the first cycle after reset.
  - An open run is discarded and no write is emitted; reset has priority over all other events.
- Accept: `in_valid && in_ready`. `in_ready` = (state != FLUSH).
- Internal registers: run_val, run_len (5b), run_start, frame_cnt.
- State IDLE, on accept:
  - run_start=base_addr, run_val=in_data, run_len=1, frame_cnt=1.
  - If in_last: emit (base_addr, 1, in_data) with done next cycle; stay IDLE.
  - Else → ACCUM.
- State ACCUM, accept where in_data==run_val and run_len<MAX_RUN (extend):
  - run_len+=1, frame_cnt+=1.
  - If in_last: emit (run_start, run_len+1, run_val) with done next cycle; → IDLE.
- State ACCUM, accept where in_data!=run_val or run_len==MAX_RUN (break):
  - Emit (run_start, run_len, run_val) next cycle.
  - New run: run_start+=run_len (mod 2^VIRTUAL_ADDR_BITS), run_val=in_data, run_len=1, frame_cnt+=1.
  - If in_last → FLUSH.
- State FLUSH (exactly one cycle, in_ready=0):
  - Emit (run_start, 1, run_val) with done next cycle; → IDLE.
- No accept: no state change. An open run remains open indefinitely; there is no timeout flush.
- Output latency: the write for a closing element appears exactly one cycle after its accept. `we` is high for one cycle per write; back-to-back writes are legal.
- total_len: updated to frame_cnt on the done cycle; holds until the next done.
- Address arithmetic: wraps modulo 2^VIRTUAL_ADDR_BITS; a run may straddle the wrap point.
- busy: 1 in ACCUM and FLUSH, 0 in IDLE.
- base_addr: ignored except at frame start.

Optional Feature:
- Macro: VARRAY_WRITER_ZERO_SKIP_EN.
- When defined: any run whose value is 0 is not emitted (we stays 0 that cycle), relying on varray reading unwritten locations as 0.
  - Address advance, total_len and frame_cnt are unchanged by the skip.
  - If the final run is zero, done still pulses, with we=0.
- When undefined: every run is written, including zero runs.

Test Plan:
- base_addr=0, stream 12,12(last) → one write (addr 0, len 2, dat 12) with done; total_len=2.
- base_addr=10, stream 6,6,6(last) → write (10,3,6) one cycle after last accept; done=1; busy=0 afterwards.
- base_addr=0, stream 3,3,5(last) → write (0,2,3) the cycle after 5 is accepted; in_ready=0 for that cycle; then write (2,1,5) with done; total_len=3.
- base_addr=0, 40 elements of 7 (last on 40th) → writes (0,31,7) then (31,9,7); done on the second write; total_len=40.
- base_addr=0xFFFE, stream 1,1,1,2(last) → writes (0xFFFE,3,1) then (0x0001,1,2).
- Reset (reset=0) after 2 accepted elements of a run → no we; in_ready=1 and busy=0 after reset.
- With VARRAY_WRITER_ZERO_SKIP_EN, base_addr=4, stream 0,0,9(last) → single write (6,1,9) with done, total_len=3. Without the macro → (4,2,0) then (6,1,9).
